// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder: segment patterns
// (gfedcba, active-high), special codes and the capture FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;

  localparam logic [3:0] BLANK_CODE   = 4'hE;
  localparam logic [3:0] INVALID_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } scan_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-high gfedcba pattern into a digit code;
// all-off decodes to blank, anything unrecognised to INVALID_CODE with a flag.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       invalid
);

  always_comb begin
    code    = INVALID_CODE;
    invalid = 1'b1;
    case (pattern)
      SEG_0:   begin code = 4'd0;       invalid = 1'b0; end
      SEG_1:   begin code = 4'd1;       invalid = 1'b0; end
      SEG_2:   begin code = 4'd2;       invalid = 1'b0; end
      SEG_3:   begin code = 4'd3;       invalid = 1'b0; end
      SEG_4:   begin code = 4'd4;       invalid = 1'b0; end
      SEG_5:   begin code = 4'd5;       invalid = 1'b0; end
      SEG_6:   begin code = 4'd6;       invalid = 1'b0; end
      SEG_7:   begin code = 4'd7;       invalid = 1'b0; end
      SEG_8:   begin code = 4'd8;       invalid = 1'b0; end
      SEG_9:   begin code = 4'd9;       invalid = 1'b0; end
      7'b0:    begin code = BLANK_CODE; invalid = 1'b0; end
      default: begin code = INVALID_CODE; invalid = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers per-digit values from a multiplexed 7-segment bus and reports
// value changes through a one-deep event buffer. Build option: SEG7_GLITCH_FILTER_EN.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int ACTIVE_LOW    = 1,
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] digit_val,
  output logic [NUM_DIGITS-1:0]   digit_invalid,
  output logic                    upd_valid,
  input  logic                    upd_ready,
  output logic [IDX_W-1:0]        upd_idx,
  output logic [3:0]              upd_digit,
  output logic                    overflow
);

  localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

`ifdef SEG7_GLITCH_FILTER_EN
  localparam logic [7:0] THRESH = 8'(STABLE_CYCLES);
`else
  // Unfiltered: every synchronised one-hot cycle is accepted at once.
  localparam logic [7:0] THRESH = (STABLE_CYCLES >= 1) ? 8'd1 : 8'd1;
`endif

  logic [6:0]            seg_s1, seg_s2, seg_n, last_seg;
  logic [NUM_DIGITS-1:0] an_s1, an_s2, an_n, last_an;
  logic [IDX_W-1:0]      an_idx;
  logic                  one_hot, changed;
  scan_state_t           state, state_next;
  logic [7:0]            cnt, cnt_next;
  logic                  capture;
  logic [3:0]            dec_code;
  logic                  dec_invalid;
  logic                  is_change, drain;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_s1   <= SEG_OFF;
      seg_s2   <= SEG_OFF;
      an_s1    <= AN_OFF;
      an_s2    <= AN_OFF;
      last_seg <= '0;
      last_an  <= '0;
    end else begin
      seg_s1   <= seg_in;
      seg_s2   <= seg_s1;
      an_s1    <= an_in;
      an_s2    <= an_s1;
      last_seg <= seg_n;
      last_an  <= an_n;
    end
  end

  // XOR against the idle level turns either polarity into active-high.
  assign seg_n   = seg_s2 ^ SEG_OFF;
  assign an_n    = an_s2 ^ AN_OFF;
  assign one_hot = ($countones(an_n) == 1);
  assign changed = (an_n != last_an) || (seg_n != last_seg);

  always_comb begin
    an_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_n[i]) an_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A fresh or altered one-hot pattern restarts the count at 1; HELD only
  // leaves on a change, so a steady pattern is captured once per phase.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    if (!one_hot) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (state == IDLE || changed) begin
      cnt_next = 8'd1;
      if (THRESH == 8'd1) begin
        state_next = HELD;
        capture    = 1'b1;
      end else begin
        state_next = SETTLE;
      end
    end else if (state == SETTLE) begin
      cnt_next = cnt + 8'd1;
      if (cnt_next == THRESH) begin
        state_next = HELD;
        capture    = 1'b1;
      end
    end
  end

  seg7_pattern_decode u_decode (
    .pattern (seg_n),
    .code    (dec_code),
    .invalid (dec_invalid)
  );

  assign is_change = capture &&
                     ((dec_code != digit_val[4*int'(an_idx) +: 4]) ||
                      (dec_invalid != digit_invalid[an_idx]));
  assign drain     = upd_valid && upd_ready;

  // A draining buffer frees its slot in the same cycle, so only a full,
  // non-draining buffer drops the new event.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digit_val     <= {NUM_DIGITS{BLANK_CODE}};
      digit_invalid <= '0;
      upd_valid     <= 1'b0;
      upd_idx       <= '0;
      upd_digit     <= '0;
      overflow      <= 1'b0;
    end else begin
      if (capture) begin
        digit_val[4*int'(an_idx) +: 4] <= dec_code;
        digit_invalid[an_idx]          <= dec_invalid;
      end
      if (is_change && (!upd_valid || drain)) begin
        upd_valid <= 1'b1;
        upd_idx   <= an_idx;
        upd_digit <= dec_code;
      end else if (drain) begin
        upd_valid <= 1'b0;
      end
      if (is_change && upd_valid && !upd_ready) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scans, a vector table
// and randomized traffic checked against a run-length reference model.
module tb_seg7_scan_decoder;

  localparam int NUM_DIGITS = 8;
`ifdef SEG7_GLITCH_FILTER_EN
  localparam int THRESH = 4;
`else
  localparam int THRESH = 1;
`endif
  localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  seg_in;
  logic [7:0]  an_in;
  logic [31:0] digit_val;
  logic [7:0]  digit_invalid;
  logic        upd_valid;
  logic        upd_ready;
  logic [2:0]  upd_idx;
  logic [3:0]  upd_digit;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         idx;
    logic [6:0] pat;
    logic [3:0] code;
    logic       inv;
  } vec_t;

  typedef struct {
    logic [2:0] idx;
    logic [3:0] digit;
    int         cyc;
  } ev_t;

  vec_t vecs [13];
  ev_t  ev_q [$];

  seg7_scan_decoder #(
    .NUM_DIGITS    (8),
    .STABLE_CYCLES (4),
    .ACTIVE_LOW    (1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .seg_in        (seg_in),
    .an_in         (an_in),
    .digit_val     (digit_val),
    .digit_invalid (digit_invalid),
    .upd_valid     (upd_valid),
    .upd_ready     (upd_ready),
    .upd_idx       (upd_idx),
    .upd_digit     (upd_digit),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one anode/segment combination (active-high view) for a number of
  // cycles; records every event that is handshaken while it is shown.
  task automatic applyStimulus(input logic [7:0] an_act, input logic [6:0] seg_act,
                               input int cycles);
    an_in  = ~an_act;
    seg_in = ~seg_act;
    for (int c = 1; c <= cycles; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (upd_valid && upd_ready) ev_q.push_back('{upd_idx, upd_digit, c});
    end
  endtask

  // Reference model: a pattern is accepted when its uninterrupted one-hot run,
  // as seen two cycles late, reaches THRESH.
  function automatic logic [4:0] modelDecode(input logic [6:0] p);
    for (int k = 0; k < 10; k++) if (p == PAT[k]) return {1'b0, 4'(k)};
    if (p == 7'h00) return {1'b0, 4'hE};
    return {1'b1, 4'hF};
  endfunction

  logic [7:0] m_s1_an, m_s2_an, m_prev_an;
  logic [6:0] m_s1_seg, m_s2_seg, m_prev_seg;
  int         m_run;
  logic [3:0] m_dig [8];
  logic [7:0] m_inv;
  logic       m_ev_valid, m_ovf;
  logic [2:0] m_ev_idx;
  logic [3:0] m_ev_digit;
  bit         model_on = 0;

  always @(posedge clk) begin : model_step
    logic [7:0] na;
    logic [6:0] ns;
    logic [4:0] dec;
    int         di;
    if (!reset_n) begin
      m_s1_an = 8'hFF; m_s2_an = 8'hFF; m_s1_seg = 7'h7F; m_s2_seg = 7'h7F;
      m_prev_an = '0; m_prev_seg = '0; m_run = 0;
      for (int k = 0; k < 8; k++) m_dig[k] = 4'hE;
      m_inv = '0; m_ev_valid = 0; m_ev_idx = '0; m_ev_digit = '0; m_ovf = 0;
      model_on = 1;
    end else begin
      na = ~m_s2_an;
      ns = ~m_s2_seg;
      if ($countones(na) != 1) m_run = 0;
      else if (m_run > 0 && na == m_prev_an && ns == m_prev_seg) m_run++;
      else m_run = 1;
      m_prev_an = na;
      m_prev_seg = ns;
      if (m_ev_valid && upd_ready) m_ev_valid = 0;
      if (m_run == THRESH) begin
        di = 0;
        for (int k = 0; k < 8; k++) if (na[k]) di = k;
        dec = modelDecode(ns);
        if (dec[3:0] != m_dig[di] || dec[4] != m_inv[di]) begin
          if (m_ev_valid) m_ovf = 1;
          else begin
            m_ev_valid = 1; m_ev_idx = 3'(di); m_ev_digit = dec[3:0];
          end
        end
        m_dig[di] = dec[3:0];
        m_inv[di] = dec[4];
      end
      m_s2_an = m_s1_an; m_s2_seg = m_s1_seg;
      m_s1_an = an_in;   m_s1_seg = seg_in;
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_dv;
    if (model_on) begin
      for (int k = 0; k < 8; k++) exp_dv[4*k +: 4] = m_dig[k];
      checkOutput("model_digit_val", digit_val, exp_dv);
      checkOutput("model_digit_invalid", {24'b0, digit_invalid}, {24'b0, m_inv});
      checkOutput("model_upd_valid", {31'b0, upd_valid}, {31'b0, m_ev_valid});
      checkOutput("model_overflow", {31'b0, overflow}, {31'b0, m_ovf});
      if (m_ev_valid) begin
        checkOutput("model_upd_idx", {29'b0, upd_idx}, {29'b0, m_ev_idx});
        checkOutput("model_upd_digit", {28'b0, upd_digit}, {28'b0, m_ev_digit});
      end
    end
  end

  initial begin
    logic [3:0] glitch_exp;
    logic [7:0] mask;
    logic [6:0] pat;

    vecs[0]  = '{0, PAT[0], 4'h0, 1'b0};
    vecs[1]  = '{1, PAT[1], 4'h1, 1'b0};
    vecs[2]  = '{2, PAT[2], 4'h2, 1'b0};
    vecs[3]  = '{3, PAT[3], 4'h3, 1'b0};
    vecs[4]  = '{4, PAT[4], 4'h4, 1'b0};
    vecs[5]  = '{5, PAT[5], 4'h5, 1'b0};
    vecs[6]  = '{6, PAT[6], 4'h6, 1'b0};
    vecs[7]  = '{7, PAT[7], 4'h7, 1'b0};
    vecs[8]  = '{0, PAT[8], 4'h8, 1'b0};
    vecs[9]  = '{1, PAT[9], 4'h9, 1'b0};
    vecs[10] = '{2, 7'h00, 4'hE, 1'b0};
    vecs[11] = '{3, 7'b1000000, 4'hF, 1'b1};
    vecs[12] = '{4, 7'b1110111, 4'hF, 1'b1};

    upd_ready = 1'b1;
    reset_n   = 1'b0;
    an_in     = 8'hFF;
    seg_in    = 7'h7F;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    checkOutput("reset_digit_val", digit_val, 32'hEEEEEEEE);
    checkOutput("reset_digit_invalid", {24'b0, digit_invalid}, 32'h0);
    checkOutput("reset_upd_valid", {31'b0, upd_valid}, 32'h0);
    checkOutput("reset_overflow", {31'b0, overflow}, 32'h0);

    // Scan "01234567": one event per digit, in order, fixed latency.
    ev_q.delete();
    for (int d = 0; d < 8; d++) applyStimulus(8'(1 << d), PAT[d], 10);
    checkOutput("scan_digit_val", digit_val, 32'h76543210);
    checkOutput("scan_event_count", ev_q.size(), 8);
    for (int k = 0; k < ev_q.size() && k < 8; k++) begin
      checkOutput("scan_event_idx", {29'b0, ev_q[k].idx}, k);
      checkOutput("scan_event_digit", {28'b0, ev_q[k].digit}, k);
      checkOutput("scan_event_latency", ev_q[k].cyc, 2 + THRESH);
    end

    // Identical re-scan must stay silent.
    ev_q.delete();
    for (int d = 0; d < 8; d++) applyStimulus(8'(1 << d), PAT[d], 10);
    checkOutput("rescan_event_count", ev_q.size(), 0);
    checkOutput("rescan_overflow", {31'b0, overflow}, 32'h0);

    // Unrecognised pattern on digit 3.
    ev_q.delete();
    applyStimulus(8'h08, 7'b0000001, 10);
    checkOutput("invalid_nibble", {28'b0, digit_val[15:12]}, 32'hF);
    checkOutput("invalid_flag", {31'b0, digit_invalid[3]}, 32'h1);
    checkOutput("invalid_event_count", ev_q.size(), 1);
    if (ev_q.size() > 0) begin
      checkOutput("invalid_event_idx", {29'b0, ev_q[0].idx}, 3);
      checkOutput("invalid_event_digit", {28'b0, ev_q[0].digit}, 32'hF);
    end

    // Back-pressure: first event parked, second dropped.
    upd_ready = 1'b0;
    applyStimulus(8'h01, PAT[8], 10);
    applyStimulus(8'h02, PAT[9], 10);
    checkOutput("bp_upd_valid", {31'b0, upd_valid}, 32'h1);
    checkOutput("bp_upd_idx", {29'b0, upd_idx}, 0);
    checkOutput("bp_upd_digit", {28'b0, upd_digit}, 8);
    checkOutput("bp_overflow", {31'b0, overflow}, 32'h1);
    checkOutput("bp_digit1_updated", {28'b0, digit_val[7:4]}, 9);
    upd_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_drained", {31'b0, upd_valid}, 32'h0);

    // Two-cycle anode glitch, then two anodes active together.
    glitch_exp = (THRESH > 2) ? 4'h2 : 4'h5;
    applyStimulus(8'h04, PAT[5], 2);
    applyStimulus(8'h00, 7'h00, 8);
    checkOutput("glitch_digit2", {28'b0, digit_val[11:8]}, {28'b0, glitch_exp});
    ev_q.delete();
    applyStimulus(8'b0000_0011, PAT[7], 10);
    checkOutput("multihot_digit_val", digit_val, {16'h7654, 4'hF, glitch_exp, 8'h98});
    checkOutput("multihot_event_count", ev_q.size(), 0);

    // One-cycle reset in the middle of a settle window.
    applyStimulus(8'h10, PAT[9], 3);
    reset_n = 1'b0;
    an_in   = 8'hFF;
    seg_in  = 7'h7F;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("midreset_digit_val", digit_val, 32'hEEEEEEEE);
    checkOutput("midreset_digit_invalid", {24'b0, digit_invalid}, 32'h0);
    checkOutput("midreset_upd_valid", {31'b0, upd_valid}, 32'h0);
    checkOutput("midreset_upd_idx", {29'b0, upd_idx}, 0);
    checkOutput("midreset_upd_digit", {28'b0, upd_digit}, 0);
    checkOutput("midreset_overflow", {31'b0, overflow}, 32'h0);
    ev_q.delete();
    applyStimulus(8'h00, 7'h00, 6);
    checkOutput("midreset_no_event", ev_q.size(), 0);
    checkOutput("midreset_hold_val", digit_val, 32'hEEEEEEEE);

    // Table of single-digit captures.
    for (int v = 0; v < 13; v++) begin
      applyStimulus(8'(1 << vecs[v].idx), vecs[v].pat, 10);
      checkOutput("table_code", {28'b0, digit_val[4*vecs[v].idx +: 4]}, {28'b0, vecs[v].code});
      checkOutput("table_invalid", {31'b0, digit_invalid[vecs[v].idx]}, {31'b0, vecs[v].inv});
    end

    // Randomized traffic, checked cycle by cycle against the model.
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0:       mask = 8'h00;
        1:       mask = 8'($urandom);
        default: mask = 8'(1 << $urandom_range(0, 7));
      endcase
      case ($urandom_range(0, 9))
        0, 1:    pat = 7'($urandom);
        2:       pat = 7'h00;
        default: pat = PAT[$urandom_range(0, 9)];
      endcase
      upd_ready = ($urandom_range(0, 3) != 0);
      applyStimulus(mask, pat, $urandom_range(1, 8));
    end
    upd_ready = 1'b1;
    applyStimulus(8'h00, 7'h00, 10);
    checkOutput("final_upd_valid", {31'b0, upd_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of anode lines scanned.
REQ-002 Parameter STABLE_CYCLES, default 4, cycles a pattern must hold before capture (range 1..255).
REQ-003 Parameter ACTIVE_LOW, default 1; 1 means seg_in/an_in are active-low, 0 means active-high.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 seg_in  input  7  multiplexed segment bus, bit0=a .. bit6=g.
REQ-007 an_in  input  NUM_DIGITS  multiplexed anode enables.
REQ-008 digit_val  output  4*NUM_DIGITS  decoded value per digit, digit i at bits [4i+3:4i].
REQ-009 digit_invalid  output  NUM_DIGITS  per digit, 1 = last capture was an unrecognised pattern.
REQ-010 upd_valid  output  1  change-event valid.
REQ-011 upd_ready  input  1  change-event ready.
REQ-012 upd_idx  output  clog2(NUM_DIGITS)  digit index of the event.
REQ-013 upd_digit  output  4  new decoded value of the event.
REQ-014 overflow  output  1  sticky, an event was dropped.

Function
REQ-015 seg_in and an_in SHALL pass through a 2-flop synchroniser, then be normalised to active-high per ACTIVE_LOW.
REQ-016 Decode (gfedcba, active-high): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111; all-off = 4'hE (blank); any other = 4'hF with invalid flag.
REQ-017 FSM states: IDLE, SETTLE, HELD.
- IDLE: anodes not exactly one-hot; no capture.
- IDLE->SETTLE: one-hot anode seen; counter loads 1.
- SETTLE: counter increments while the anode and seg values equal the previous cycle.
- SETTLE->HELD: counter reaches STABLE_CYCLES.
- HELD: wait.
- Any state -> IDLE: zero or multiple anodes active.
- SETTLE/HELD -> SETTLE (counter=1): anode or seg value changes while still one-hot.
REQ-018 On the SETTLE->HELD transition, digit_val[idx] and digit_invalid[idx] SHALL update on that clock edge (total latency: 2 sync cycles + STABLE_CYCLES).
REQ-019 A change event SHALL be raised only when the captured value or invalid flag differs from the stored one; same-value recaptures SHALL raise no event.
REQ-020 Event buffer depth 1: upd_valid/upd_idx/upd_digit SHALL hold stable until the cycle upd_valid && upd_ready.
REQ-021 New event while buffer full and not draining that cycle: the new event is dropped, overflow set, digit_val still updated.
REQ-022 New event in the same cycle the buffer drains: the new event SHALL load with no gap and no drop.
REQ-023 HELD SHALL never recapture; a persistent pattern yields at most one capture per scan phase.

Reset
REQ-024 While reset_n=0 at a clk edge:
- digit_val = all 4'hE
- digit_invalid = 0
- upd_valid = 0, upd_idx = 0, upd_digit = 0
- overflow = 0
- FSM = IDLE, counter = 0, synchroniser flops cleared to the inactive level.
REQ-025 Reset mid-SETTLE SHALL abandon the capture; no partial update.
REQ-026 Reset is the only way to clear overflow.

Configuration
REQ-027 Macro SEG7_GLITCH_FILTER_EN.
- Defined: SETTLE uses STABLE_CYCLES as in REQ-017.
- Undefined: STABLE_CYCLES is ignored and capture occurs on the first synchronised one-hot cycle (threshold 1).

Structure
REQ-028 Package seg7_pkg SHALL hold the ten segment pattern constants, BLANK_CODE=4'hE, INVALID_CODE=4'hF, and the FSM state enum.
REQ-029 Sub-module seg7_pattern_decode (combinational: 7-bit pattern -> 4-bit code plus invalid) SHALL be instantiated once.

Verification
REQ-030 Bench SHALL cover, with ACTIVE_LOW=1, STABLE_CYCLES=4 and the macro defined:
- Scan 8 digits "01234567", each anode held 10 cycles -> digit_val=32'h76543210, 8 events in idx order 0..7, each event 6 cycles after its anode edge.
- Re-scan the same digits -> no events, overflow=0.
- Digit 3 shows pattern 0000001 -> digit_val[15:12]=4'hF, digit_invalid[3]=1, event idx=3 digit=F.
- upd_ready held 0 across two changed digits -> first event held stable, second dropped, overflow=1; then upd_ready=1 -> first event accepted, upd_valid=0 next cycle.
- Anode glitch of 2 cycles, or an_in=8'b11111100 (two digits active) -> no capture, FSM IDLE.
- reset_n=0 for 1 cycle during SETTLE -> all outputs at REQ-024 values, no event.
